// File: rtl/key_search_pkg.sv
// Shared types and constants for the brute-force key-search controller.
package key_search_pkg;

  localparam int unsigned KEY_W = 24;

  // Printable ASCII window, inclusive on both ends.
  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone,
    StCheck,
    StNext,
    StFound,
    StDoneFail,
    StDone
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/key_search_ctrl_if.sv
// Bundle of the search handshake, the core en/rdy handshake and the plaintext read port.
interface key_search_ctrl_if;
  import key_search_pkg::*;

  logic             en;
  logic             rdy;
  logic             stop;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             core_en;
  logic             core_rdy;
  logic [7:0]       pt_addr;
  logic [7:0]       pt_rddata;

  // Controller side.
  modport master (
    input  en, stop, core_rdy, pt_rddata,
    output rdy, key, key_valid, core_en, pt_addr
  );

  // Environment side: search requester, decryption core and plaintext memory.
  modport slave (
    output en, stop, core_rdy, pt_rddata,
    input  rdy, key, key_valid, core_en, pt_addr
  );

endinterface

// File: rtl/pt_checker.sv
// Reads the length-prefixed plaintext and checks every byte for printable ASCII.
// Reads are pipelined: one address per cycle, data returns two edges after the
// address register is loaded. Bytes are judged strictly in order, so the first
// failing byte ends the scan before any later byte can be considered.
module pt_checker
  import key_search_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] pt_rddata_i,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] pt_addr_o
);

  logic       busy_q, busy_d;
  logic [7:0] addr_q, addr_d;
  // v1: addr_q holds a live read; v2/i2: read whose data is on pt_rddata_i now.
  logic       v1_q, v1_d;
  logic       v2_q, v2_d;
  logic [7:0] i2_q, i2_d;
  logic [7:0] len_q, len_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fin;
  logic       res;

  // Next-state: issue the next address, retire the returning byte, finish on a verdict.
  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    i2_d   = i2_q;
    len_d  = len_q;
    done_d = 1'b0;
    pass_d = pass_q;
    fin    = 1'b0;
    res    = 1'b0;
    if (start_i) begin
      busy_d = 1'b1;
      addr_d = 8'h00;
      v1_d   = 1'b1;
      v2_d   = 1'b0;
      pass_d = 1'b0;
    end else if (busy_q) begin
      v2_d = v1_q;
      i2_d = addr_q;
      // Speculative issue; bytes past len are ignored. Address stops at 255.
      if (addr_q != 8'hFF) begin
        addr_d = addr_q + 8'd1;
        v1_d   = 1'b1;
      end else begin
        v1_d   = 1'b0;
      end
      if (v2_q) begin
        if (i2_q == 8'h00) begin
          len_d = pt_rddata_i;
          if (pt_rddata_i == 8'h00) begin
            fin = 1'b1;
            res = 1'b1;
          end
        end else if (i2_q <= len_q) begin
          if (!is_printable(pt_rddata_i)) begin
            fin = 1'b1;
            res = 1'b0;
          end else if (i2_q == len_q) begin
            fin = 1'b1;
            res = 1'b1;
          end
        end
      end
      if (fin) begin
        busy_d = 1'b0;
        addr_d = 8'h00;
        v1_d   = 1'b0;
        v2_d   = 1'b0;
        done_d = 1'b1;
        pass_d = res;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      addr_q <= 8'h00;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      i2_q   <= 8'h00;
      len_q  <= 8'h00;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      i2_q   <= i2_d;
      len_q  <= len_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign pt_addr_o = addr_q;

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key-search controller: runs the decryption core once per candidate
// key and accepts the first key whose plaintext is entirely printable.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001,
  parameter logic [KEY_W-1:0] KEY_MAX   = 24'hFFFFFF
) (
  input logic               clk,
  input logic               rst_n,
  key_search_ctrl_if.master bus_io
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             rdy_q, rdy_d;
  logic             core_en_q, core_en_d;
  logic             stop_q, stop_d;

  logic             chk_start;
  logic             chk_done;
  logic             chk_pass;
  logic [7:0]       chk_addr;

  // One extra bit so the last-key test never wraps.
  logic [KEY_W:0]   key_next_wide;
  logic             last_key;

  assign key_next_wide = {1'b0, key_q} + {1'b0, KEY_STEP};
  assign last_key      = key_next_wide > {1'b0, KEY_MAX};

  // Next-state and registered-output logic of the search FSM.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    rdy_d       = rdy_q;
    core_en_d   = 1'b0;
    stop_d      = stop_q;
    chk_start   = 1'b0;
    // Stop is only remembered here; it is acted on between core runs.
    if (state_q != StIdle && bus_io.stop) begin
      stop_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (bus_io.en) begin
          key_d       = KEY_START;
          key_valid_d = 1'b0;
          stop_d      = 1'b0;
          rdy_d       = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (bus_io.core_rdy) begin
          core_en_d = 1'b1;
          state_d   = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!bus_io.core_rdy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus_io.core_rdy) begin
          chk_start = 1'b1;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        if (chk_done) begin
          state_d = chk_pass ? StFound : StNext;
        end
      end
      StNext: begin
        if (stop_q || last_key) begin
          state_d = StDoneFail;
        end else begin
          key_d   = key_next_wide[KEY_W-1:0];
          state_d = StStart;
        end
      end
      StFound: begin
        key_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDoneFail: begin
        key_valid_d = 1'b0;
        state_d     = StDone;
      end
      StDone: begin
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_q       <= KEY_START;
      key_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
      core_en_q   <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      rdy_q       <= rdy_d;
      core_en_q   <= core_en_d;
      stop_q      <= stop_d;
    end
  end

  pt_checker u_pt_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (chk_start),
    .pt_rddata_i (bus_io.pt_rddata),
    .done_o      (chk_done),
    .pass_o      (chk_pass),
    .pt_addr_o   (chk_addr)
  );

  assign bus_io.rdy       = rdy_q;
  assign bus_io.key       = key_q;
  assign bus_io.key_valid = key_valid_q;
  assign bus_io.core_en   = core_en_q;
  assign bus_io.pt_addr   = chk_addr;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: four instances with different key ranges,
// each paired with a behavioural decryption core and plaintext memory.
module tb_key_search_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_search_ctrl_if bus [4] ();

  logic [3:0]  en_s;
  logic [3:0]  stop_s;
  logic [3:0]  hold_s;
  logic [3:0]  core_rdy_s;
  logic [3:0]  rdy_s;
  logic [3:0]  kv_s;
  logic [3:0]  core_en_s;
  logic [23:0] key_s  [4];
  logic [7:0]  addr_s [4];
  int          runs_s [4];
  int          viol_s [4];
  int          mode_s [4];
  logic [23:0] tgt_s  [4];

  int checks = 0;
  int errors = 0;

  key_search_ctrl #(.KEY_START(24'h000000), .KEY_STEP(24'h000001), .KEY_MAX(24'hFFFFFF))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus_io(bus[0]));
  key_search_ctrl #(.KEY_START(24'h000000), .KEY_STEP(24'h000001), .KEY_MAX(24'h00000F))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus_io(bus[1]));
  key_search_ctrl #(.KEY_START(24'h000001), .KEY_STEP(24'h000002), .KEY_MAX(24'h000021))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus_io(bus[2]));
  key_search_ctrl #(.KEY_START(24'h000000), .KEY_STEP(24'h000002), .KEY_MAX(24'hFFFFFF))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus_io(bus[3]));

  // Plaintext the core writes for key k. Key 0 can be overridden by a boundary pattern.
  function automatic logic [7:0] pt_byte(input logic [23:0] k, input int mode,
                                         input logic [23:0] tgt, input int i);
    logic [7:0] b [6];
    if (k == 24'h0 && mode == 1)      b = '{8'd3, 8'h20, 8'h7E, 8'h41, 8'h01, 8'h01};
    else if (k == 24'h0 && mode == 2) b = '{8'd3, 8'h20, 8'h7E, 8'h1F, 8'h41, 8'h41};
    else if (k == 24'h0 && mode == 3) b = '{8'd3, 8'h20, 8'h7E, 8'h7F, 8'h41, 8'h41};
    else if (k == 24'h0 && mode == 4) b = '{8'd0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    else if (k == tgt)                b = '{8'd5, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    else                              b = '{8'd4, 8'h41, 8'h01, 8'h42, 8'h43, 8'h01};
    if (i < 6) return b[i[2:0]];
    return 8'h01;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_core
    logic        crdy_q = 1'b1;
    logic [7:0]  rd_q   = 8'h00;
    logic [7:0]  mem [256];
    logic [23:0] cap_key = 24'h0;
    int          busy = 0;
    int          runs = 0;
    int          viol = 0;

    assign core_rdy_s[g]     = crdy_q & ~hold_s[g];
    assign bus[g].en         = en_s[g];
    assign bus[g].stop       = stop_s[g];
    assign bus[g].core_rdy   = core_rdy_s[g];
    assign bus[g].pt_rddata  = rd_q;
    assign rdy_s[g]          = bus[g].rdy;
    assign kv_s[g]           = bus[g].key_valid;
    assign core_en_s[g]      = bus[g].core_en;
    assign key_s[g]          = bus[g].key;
    assign addr_s[g]         = bus[g].pt_addr;
    assign runs_s[g]         = runs;
    assign viol_s[g]         = viol;

    // Core: busy four cycles after an accepted start, then writes plaintext and reports ready.
    always @(posedge clk) begin
      rd_q <= mem[bus[g].pt_addr];
      if (bus[g].core_en && !core_rdy_s[g]) viol <= viol + 1;
      if (bus[g].core_en) runs <= runs + 1;
      if (busy != 0) begin
        busy <= busy - 1;
        if (busy == 1) begin
          for (int i = 0; i < 256; i++) mem[i] <= pt_byte(cap_key, mode_s[g], tgt_s[g], i);
          crdy_q <= 1'b1;
        end
      end else if (bus[g].core_en && core_rdy_s[g]) begin
        crdy_q  <= 1'b0;
        busy    <= 4;
        cap_key <= bus[g].key;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input int g);
    int n = 0;
    while (!rdy_s[g] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("rdy_timeout", 32'(rdy_s[g]), 32'd1);
  endtask

  task automatic pulse_en(input int g);
    @(negedge clk);
    en_s[g] = 1'b1;
    @(negedge clk);
    en_s[g] = 1'b0;
  endtask

  task automatic run_search(input int g);
    pulse_en(g);
    wait_rdy(g);
  endtask

  int r0;
  int n;

  initial begin
    rst_n  = 1'b0;
    en_s   = '0;
    stop_s = '0;
    hold_s = '0;
    for (int i = 0; i < 4; i++) begin
      mode_s[i] = 0;
      tgt_s[i]  = 24'h000018;
    end
    repeat (3) @(negedge clk);
    check("rst_rdy",     32'(rdy_s[0]),     32'd1);
    check("rst_key",     32'(key_s[0]),     32'h0);
    check("rst_kv",      32'(kv_s[0]),      32'd0);
    check("rst_core_en", 32'(core_en_s[0]), 32'd0);
    check("rst_addr",    32'(addr_s[0]),    32'h0);
    check("rst_key_st1", 32'(key_s[2]),     32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Main search: only key 0x18 decrypts to printable text.
    r0 = runs_s[0];
    run_search(0);
    check("main_key",  32'(key_s[0]),  32'h18);
    check("main_kv",   32'(kv_s[0]),   32'd1);
    check("main_runs", runs_s[0] - r0, 32'd25);
    check("main_rdy",  32'(rdy_s[0]),  32'd1);
    repeat (5) @(negedge clk);
    check("main_hold", 32'(key_s[0]),  32'h18);

    // Boundary bytes at key 0; key 1 is the fallback printable key.
    tgt_s[0] = 24'h000001;
    mode_s[0] = 1;
    r0 = runs_s[0];
    run_search(0);
    check("b20_7e_key",  32'(key_s[0]), 32'h0);
    check("b20_7e_kv",   32'(kv_s[0]),  32'd1);
    check("b20_7e_runs", runs_s[0] - r0, 32'd1);
    mode_s[0] = 2;
    r0 = runs_s[0];
    run_search(0);
    check("b1f_key",  32'(key_s[0]), 32'h1);
    check("b1f_runs", runs_s[0] - r0, 32'd2);
    mode_s[0] = 3;
    r0 = runs_s[0];
    run_search(0);
    check("b7f_key",  32'(key_s[0]), 32'h1);
    check("b7f_runs", runs_s[0] - r0, 32'd2);
    mode_s[0] = 4;
    r0 = runs_s[0];
    run_search(0);
    check("len0_key",  32'(key_s[0]), 32'h0);
    check("len0_kv",   32'(kv_s[0]),  32'd1);
    check("len0_runs", runs_s[0] - r0, 32'd1);
    mode_s[0] = 0;
    tgt_s[0]  = 24'h000018;

    // Exhaust a 16-key range with no printable key.
    run_search(1);
    check("exh_runs", runs_s[1], 32'd16);
    check("exh_kv",   32'(kv_s[1]),  32'd0);
    check("exh_key",  32'(key_s[1]), 32'hF);
    check("exh_rdy",  32'(rdy_s[1]), 32'd1);

    // Parallel halves: odd keys never hit 0x18, even keys do.
    run_search(2);
    check("odd_runs", runs_s[2], 32'd17);
    check("odd_kv",   32'(kv_s[2]),  32'd0);
    check("odd_key",  32'(key_s[2]), 32'h21);
    run_search(3);
    check("even_runs", runs_s[3], 32'd13);
    check("even_kv",   32'(kv_s[3]),  32'd1);
    check("even_key",  32'(key_s[3]), 32'h18);

    // Stop during the third core run: that run finishes, no fourth start.
    r0 = runs_s[0];
    pulse_en(0);
    n = 0;
    while (!(runs_s[0] - r0 == 3 && !core_rdy_s[0]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("stop_wait_timeout", 32'(runs_s[0] - r0), 32'd3);
    @(negedge clk);
    stop_s[0] = 1'b1;
    @(negedge clk);
    stop_s[0] = 1'b0;
    wait_rdy(0);
    check("stop_runs", runs_s[0] - r0, 32'd3);
    check("stop_kv",   32'(kv_s[0]),  32'd0);
    check("stop_key",  32'(key_s[0]), 32'h2);

    // Reset in the middle of a plaintext scan.
    r0 = runs_s[0];
    pulse_en(0);
    n = 0;
    while (!(runs_s[0] - r0 >= 2 && addr_s[0] != 8'h00) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("chk_wait_timeout", 32'(addr_s[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy",     32'(rdy_s[0]),     32'd1);
    check("mid_rst_key",     32'(key_s[0]),     32'h0);
    check("mid_rst_kv",      32'(kv_s[0]),      32'd0);
    check("mid_rst_core_en", 32'(core_en_s[0]), 32'd0);
    check("mid_rst_addr",    32'(addr_s[0]),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_s[0] = 1'b1;
    r0 = runs_s[0];
    pulse_en(0);
    repeat (10) @(negedge clk);
    check("hold_no_start", runs_s[0] - r0, 32'd0);
    check("hold_busy_rdy", 32'(rdy_s[0]), 32'd0);
    hold_s[0] = 1'b0;
    wait_rdy(0);
    check("restart_key",  32'(key_s[0]), 32'h18);
    check("restart_kv",   32'(kv_s[0]),  32'd1);
    check("restart_runs", runs_s[0] - r0, 32'd25);

    for (int i = 0; i < 4; i++) check("core_en_while_busy", viol_s[i], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_search_ctrl.md
Name: key_search_ctrl

Overview:
- Brute-force key-search controller; the initiator side of the decryption core's en/rdy handshake and the reader of the plaintext memory the core writes.
- Per candidate key: starts one core run, waits for completion, then scans the length-prefixed plaintext for printable ASCII.
- Steps KEY_START, +KEY_STEP, ... up to KEY_MAX; several instances with interleaved start/step form a parallel cracker.

Parameters:
KEY_START, 24'h000000, first candidate key
KEY_STEP, 24'h000001, candidate increment (instance count when parallel)
KEY_MAX, 24'hFFFFFF, last candidate allowed

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start search; honoured only while rdy=1
rdy  out  1  idle/finished, ready for en
stop  in  1  abort request (another instance found the key)
key  out  24  current candidate; the found key when key_valid=1
key_valid  out  1  search succeeded; valid while rdy=1
core_en  out  1  one-cycle start pulse to decryption core
core_rdy  in  1  decryption core ready
pt_addr  out  8  plaintext memory read address
pt_rddata  in  8  plaintext memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE, rdy=1, key=KEY_START, key_valid=0, core_en=0, pt_addr=0, stop latch cleared. A mid-run reset abandons all work immediately.
- All outputs are registered.
- Memory timing: an address stable at edge k gives data sampled at edge k+1.
- IDLE: rdy=1. en=1 at an edge -> key=KEY_START, key_valid=0, stop latch cleared, rdy=0, go START.
- START: wait until core_rdy=1, then pulse core_en exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY: wait core_rdy=0 -> WAIT_DONE.
- WAIT_DONE: wait core_rdy=1 -> RD_LEN with pt_addr=0.
- RD_LEN: capture len=pt_rddata.
  - len=0 -> FOUND (an empty message passes).
  - otherwise idx=1, pt_addr=1 -> CHECK.
- CHECK: each sampled byte must lie in 0x20..0x7E inclusive.
  - Fail -> NEXT.
  - Pass with idx==len -> FOUND.
  - Otherwise idx+1, pt_addr+1.
  - Address reads may be pipelined; a fail must not be masked by a later byte.
- NEXT:
  - If stop latch set, or key > KEY_MAX-KEY_STEP (24-bit compare, no wrap) -> DONE_FAIL.
  - Else key=key+KEY_STEP -> START.
- FOUND: key_valid=1, key held -> DONE.
- DONE_FAIL: key_valid=0 -> DONE.
- DONE: rdy=1, state IDLE; key/key_valid hold until the next en.
- stop: latched in any non-IDLE cycle. Takes effect only at NEXT, so a core run in flight is never abandoned. If FOUND is reached in the same run, FOUND wins.
- en while rdy=0: ignored.
- core_en: never asserted while core_rdy=0.
- pt_addr: idx never exceeds 255 (len max 255); no address wrap.

Decomposition:
- Package key_search_pkg: state enum; ASCII_MIN=8'h20, ASCII_MAX=8'h7E; KEY_W=24.
- One sub-module, pt_checker: the RD_LEN/CHECK read-and-compare loop, with a start/done/pass interface.

Test Plan:
- Behavioural core model writes printable plaintext only for key 24'h000018; KEY_START=0, STEP=1 -> key=24'h000018, key_valid=1, exactly 25 core_en pulses, rdy=1.
- Boundary bytes: len=3 with 20 7E 41 -> pass. Separately 1F and 7F in the last position -> fail. Also len=0 -> pass.
- Exhaust: KEY_MAX=24'h00000F, no valid key -> 16 runs, rdy=1, key_valid=0, key=24'h00000F.
- Parallel: STEP=2, START=1, valid key 24'h000018 -> never found, terminates at KEY_MAX. With START=0 -> found after 13 runs.
- stop pulsed during the 3rd WAIT_DONE -> that run completes, no 4th core_en, key_valid=0.
- rst_n low mid-CHECK, then en -> clean restart at KEY_START; core_en is only issued when core_rdy=1.
